// File: rtl/road_input_conditioner_if.sv
// Sensor/walk bundle between the raw-input side and the intersection controller.
// master drives raw inputs and acknowledges; slave (the conditioner) returns levels and requests.
interface road_input_conditioner_if;
    logic sensor_raw;
    logic walk_raw;
    logic sensor_ack;
    logic walk_ack;
    logic sensor_level;
    logic sensor_req;
    logic walk_req;
    logic walk_busy;

    modport master (
        output sensor_raw, walk_raw, sensor_ack, walk_ack,
        input  sensor_level, sensor_req, walk_req, walk_busy
    );

    modport slave (
        input  sensor_raw, walk_raw, sensor_ack, walk_ack,
        output sensor_level, sensor_req, walk_req, walk_busy
    );
endinterface

// File: rtl/road_input_conditioner.sv
// Sync -> debounce -> rise detect -> request latch per channel; request sets DEBOUNCE_CYCLES+3 edges after a clean raw change.
// Optional walk re-arm lockout after a walk grant is built when WALK_HOLDOFF_EN is defined.
module road_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLDOFF_CYCLES  = 5000
) (
    input  logic                      clk,
    input  logic                      reset,
    road_input_conditioner_if.slave   bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, PENDING} req_state_t;

    // Bit 0 is the sensor channel, bit 1 the walk channel.
    logic [1:0]    s1, s2, stable, stable_d, rise;
    logic [CW-1:0] db_cnt [2];
    req_state_t    sens_state, sens_next, walk_state, walk_next;
    logic          walk_busy_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1        <= '0;
            s2        <= '0;
            stable    <= '0;
            stable_d  <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            s1       <= {bus.walk_raw, bus.sensor_raw};
            s2       <= s1;
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise = stable & ~stable_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sens_state <= IDLE;
            walk_state <= IDLE;
        end else begin
            sens_state <= sens_next;
            walk_state <= walk_next;
        end
    end

    // A rise in the same cycle as an ack keeps the request pending.
    always_comb begin
        sens_next = sens_state;
        walk_next = walk_state;
        case (sens_state)
            IDLE:    if (rise[0]) sens_next = PENDING;
            PENDING: if (!rise[0] && bus.sensor_ack) sens_next = IDLE;
        endcase
        case (walk_state)
            IDLE:    if (rise[1] && !walk_busy_int) walk_next = PENDING;
            PENDING: if (!rise[1] && bus.walk_ack) walk_next = IDLE;
        endcase
    end

`ifdef WALK_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    logic [HW-1:0] hold_cnt;
    logic          busy_q;
    logic          walk_ack_taken;

    assign walk_ack_taken = (walk_state == PENDING) && !rise[1] && bus.walk_ack;

    // Only a grant that actually retires a pending walk arms the lockout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            busy_q   <= 1'b0;
        end else if (walk_ack_taken) begin
            hold_cnt <= HW'(HOLDOFF_CYCLES);
            busy_q   <= (HOLDOFF_CYCLES != 0);
        end else if (busy_q) begin
            hold_cnt <= hold_cnt - HW'(1);
            if (hold_cnt == HW'(1)) busy_q <= 1'b0;
        end
    end

    assign walk_busy_int = busy_q;
`else
    assign walk_busy_int = 1'b0;
`endif

    assign bus.sensor_level = stable[0];
    assign bus.sensor_req   = (sens_state == PENDING);
    assign bus.walk_req     = (walk_state == PENDING);
    assign bus.walk_busy    = walk_busy_int;
endmodule

// File: tb/tb_road_input_conditioner.sv
// Directed bench for road_input_conditioner with DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8.
// Expectations for the walk lockout window follow whether WALK_HOLDOFF_EN is defined.
module tb_road_input_conditioner;
`ifdef WALK_HOLDOFF_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk;
    logic reset;
    int   passes = 0;
    int   total  = 0;

    road_input_conditioner_if bus ();

    road_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLDOFF_CYCLES  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    endtask

    initial begin
        reset          = 1'b0;
        bus.sensor_raw = 1'b0;
        bus.walk_raw   = 1'b0;
        bus.sensor_ack = 1'b0;
        bus.walk_ack   = 1'b0;

        // Reset state
        ticks(2);
        check("rst_sensor_level", bus.sensor_level, 1'b0);
        check("rst_sensor_req",   bus.sensor_req,   1'b0);
        check("rst_walk_req",     bus.walk_req,     1'b0);
        check("rst_walk_busy",    bus.walk_busy,    1'b0);

        // Sensor press: level after edge 6, request after edge 7
        reset          = 1'b1;
        bus.sensor_raw = 1'b1;
        ticks(5);
        check("sens_level_e5", bus.sensor_level, 1'b0);
        tick();
        check("sens_level_e6", bus.sensor_level, 1'b1);
        check("sens_req_e6",   bus.sensor_req,   1'b0);
        tick();
        check("sens_req_e7",   bus.sensor_req,   1'b1);

        // Debounced fall leaves the request pending
        bus.sensor_raw = 1'b0;
        ticks(6);
        check("sens_fall_level", bus.sensor_level, 1'b0);
        check("sens_fall_req",   bus.sensor_req,   1'b1);

        // New rise coincides with a one-cycle ack: rise wins
        bus.sensor_raw = 1'b1;
        ticks(6);
        check("sens_rerise_level", bus.sensor_level, 1'b1);
        bus.sensor_ack = 1'b1;
        tick();
        bus.sensor_ack = 1'b0;
        check("sens_rise_beats_ack", bus.sensor_req, 1'b1);
        bus.sensor_ack = 1'b1;
        tick();
        bus.sensor_ack = 1'b0;
        check("sens_ack_clears", bus.sensor_req, 1'b0);
        bus.sensor_ack = 1'b1;
        tick();
        bus.sensor_ack = 1'b0;
        check("sens_ack_idle", bus.sensor_req, 1'b0);

        // Walk glitches of 3 cycles with 2-cycle gaps never register
        for (int k = 0; k < 3; k++) begin
            bus.walk_raw = 1'b1;
            ticks(3);
            bus.walk_raw = 1'b0;
            ticks(2);
            check("walk_glitch_req", bus.walk_req, 1'b0);
        end
        ticks(4);
        check("walk_glitch_tail", bus.walk_req, 1'b0);
        bus.walk_raw = 1'b1;
        ticks(6);
        check("walk_hold_e6", bus.walk_req, 1'b0);
        tick();
        check("walk_hold_e7", bus.walk_req, 1'b1);

        // Walk debounces low while the request stays pending
        bus.walk_raw = 1'b0;
        ticks(6);
        check("walk_fall_req", bus.walk_req, 1'b1);

        // Grant with walk re-pressed; its rise lands inside the lockout window
        bus.walk_raw = 1'b1;
        bus.walk_ack = 1'b1;
        tick();
        bus.walk_ack = 1'b0;
        check("walk_grant_req",  bus.walk_req,  1'b0);
        check("walk_grant_busy", bus.walk_busy, HOLD);
        tick();
        bus.walk_ack = 1'b1;
        tick();
        bus.walk_ack = 1'b0;
        check("walk_idle_ack_e3", bus.walk_req, 1'b0);
        ticks(3);
        check("walk_win_req_e6", bus.walk_req, 1'b0);
        tick();
        check("walk_win_req_e7",  bus.walk_req,  !HOLD);
        check("walk_win_busy_e7", bus.walk_busy, HOLD);
        tick();
        check("walk_win_busy_e8", bus.walk_busy, HOLD);
        tick();
        check("walk_win_busy_e9", bus.walk_busy, 1'b0);

        bus.walk_ack = 1'b1;
        tick();
        bus.walk_ack = 1'b0;
        check("walk_post_ack_req",  bus.walk_req,  1'b0);
        check("walk_post_ack_busy", bus.walk_busy, 1'b0);

        // Rise after the lockout latches normally
        bus.walk_raw = 1'b0;
        ticks(6);
        bus.walk_raw = 1'b1;
        ticks(6);
        check("walk_after_e6", bus.walk_req, 1'b0);
        tick();
        check("walk_after_e7", bus.walk_req, 1'b1);

        // Asynchronous reset between edges drops the request at once
        reset = 1'b0;
        #1;
        check("arst_walk_req",     bus.walk_req,     1'b0);
        check("arst_sensor_level", bus.sensor_level, 1'b0);
        #2;
        reset = 1'b1;
        ticks(6);
        check("rel_walk_req_e6",   bus.walk_req,     1'b0);
        check("rel_sens_level_e6", bus.sensor_level, 1'b1);
        tick();
        check("rel_walk_req_e7",   bus.walk_req,   1'b1);
        check("rel_sens_req_e7",   bus.sensor_req, 1'b1);
        check("rel_walk_busy",     bus.walk_busy,  1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
